// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// pc_sequencer: fetch/decode/exec sequencer that owns the PC and the instruction register
module pc_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic                   ir_valid,
  input  logic                   exec_done,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   halt,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   halted
);
  typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, HALT} state_t;
  state_t state, next_state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= BOOT;
    else state <= next_state;
  always_comb
    next_state = state == BOOT   ? FETCH :
                 state == FETCH  ? (imem_ack ? DECODE : FETCH) :
                 state == DECODE ? EXEC :
                 state == EXEC   ? (exec_done ? (halt ? HALT : FETCH) : EXEC) :
                 HALT;
  // outputs decode from state alone so an async reset clears them without a clock
  always_comb begin
    imem_req = state == FETCH;
    ir_valid = state == DECODE;
    halted = state == HALT;
  end
  assign imem_addr = pc;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc <= RESET_PC;
      ir <= '0;
    end else begin
      if (state == FETCH && imem_ack) ir <= imem_data;
      if (state == EXEC && exec_done) pc <= branch_taken ? branch_target : pc + PC_WIDTH'(1);
    end
endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
// tb_pc_sequencer: directed runs with a memory/execute responder and an ir_valid scoreboard
module tb_pc_sequencer;
  logic clk, rst;
  logic imem_req, imem_ack, ir_valid, exec_done, branch_taken, halt, halted;
  logic [7:0] imem_addr, branch_target, pc;
  logic [15:0] imem_data, ir;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .pc(pc), .halted(halted)
  );

  typedef struct {
    logic [7:0] addr;
    logic [15:0] ir;
    int period;
  } exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int ack_delay, exec_delay;
  logic noise, glitch;
  logic br[8];
  logic [7:0] tgt[8];
  logic hl[8];

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [7:0] a, input int p);
    exp_t e;
    e.addr = a;
    e.ir = 16'h1000 + 16'(a);
    e.period = p;
    sb.push_back(e);
  endtask

  task automatic prog_clear();
    for (int i = 0; i < 8; i++) begin
      br[i] = 0;
      tgt[i] = 8'h00;
      hl[i] = 0;
    end
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!halted && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!halted) chk("halt_timeout", 0, 1);
  endtask

  // instruction memory: acks after ack_delay wait cycles, data = 0x1000 + address
  initial begin
    int wcnt = 0;
    imem_ack = 0;
    imem_data = 16'h0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        imem_ack = 0;
        wcnt = 0;
      end else if (imem_req) begin
        imem_ack = wcnt == ack_delay;
        wcnt = imem_ack ? 0 : wcnt + 1;
      end else begin
        imem_ack = noise ? ~imem_ack : 1'b0;
        wcnt = 0;
      end
      imem_data = 16'h1000 + 16'(imem_addr);
    end
  end

  // execute stage: exec_done after exec_delay low cycles, branch/halt from per-instruction table
  initial begin
    int cnt = 0, idx = 0;
    logic in_exec = 0;
    exec_done = 0;
    branch_taken = 0;
    branch_target = 8'h00;
    halt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_exec = 0;
        idx = 0;
        exec_done = 0;
        branch_taken = 0;
        halt = 0;
      end else if (ir_valid) begin
        in_exec = 1;
        cnt = 0;
        exec_done = 0;
        branch_taken = glitch;
        branch_target = 8'hAA;
        halt = glitch;
      end else if (in_exec) begin
        if (cnt == exec_delay) begin
          exec_done = 1;
          branch_taken = idx < 8 ? br[idx] : 1'b0;
          branch_target = idx < 8 ? tgt[idx] : 8'h00;
          halt = idx < 8 ? hl[idx] : 1'b0;
          in_exec = 0;
          idx++;
        end else begin
          exec_done = 0;
          branch_taken = glitch;
          branch_target = 8'hAA;
          halt = glitch;
        end
        cnt++;
      end else begin
        exec_done = noise ? ~exec_done : 1'b0;
        branch_taken = noise;
        branch_target = 8'h55;
        halt = noise;
      end
    end
  end

  // monitor: scoreboard on ir_valid, fetch-address stability while imem_req is high
  initial begin
    int cyc = 0, last = -1;
    logic prev_req = 0;
    logic [7:0] fa = 8'h00;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        last = -1;
        prev_req = 0;
      end else begin
        if (imem_req) begin
          if (prev_req) chk("addr_stable", imem_addr, fa);
          else fa = imem_addr;
        end
        prev_req = imem_req;
        if (ir_valid) begin
          if (sb.size() == 0) chk("unexpected_ir_valid", 1, 0);
          else begin
            e = sb.pop_front();
            chk("ir", ir, e.ir);
            chk("pc_at_decode", pc, e.addr);
            if (e.period != 0 && last >= 0) chk("period", cyc - last, e.period);
          end
          last = cyc;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    noise = 0;
    glitch = 0;
    ack_delay = 0;
    exec_delay = 0;
    prog_clear();
    // run 1: zero-wait sequential fetch, halt on the instruction at pc 5
    hl[5] = 1;
    expect_fetch(8'h00, 0);
    for (int i = 1; i < 6; i++) expect_fetch(8'(i), 3);
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir", ir, 0);
    rst = 1;
    #1 chk("boot_req", imem_req, 0);
    @(negedge clk);
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, 0);
    wait_halt();
    chk("halt_pc", pc, 6);
    chk("halted", halted, 1);
    noise = 1;
    repeat (20) begin
      @(negedge clk);
      chk("halt_req", imem_req, 0);
      chk("halt_pc_frozen", pc, 6);
      chk("halt_stays", halted, 1);
    end
    noise = 0;
    // run 2: wait states, ignored halt/branch glitches, branch to 0x10, 0xFF, wrap to 0x00
    @(negedge clk);
    rst = 0;
    prog_clear();
    br[1] = 1; tgt[1] = 8'h10;
    br[2] = 1; tgt[2] = 8'hFF;
    hl[4] = 1;
    ack_delay = 3;
    exec_delay = 2;
    glitch = 1;
    expect_fetch(8'h00, 0);
    expect_fetch(8'h01, 8);
    expect_fetch(8'h10, 8);
    expect_fetch(8'hFF, 8);
    expect_fetch(8'h00, 8);
    repeat (2) @(negedge clk);
    chk("rst2_halted", halted, 0);
    rst = 1;
    wait_halt();
    chk("wrap_halt_pc", pc, 1);
    // run 3: async reset in the middle of the fetch at pc 0x42
    @(negedge clk);
    rst = 0;
    prog_clear();
    br[0] = 1; tgt[0] = 8'h42;
    ack_delay = 5;
    exec_delay = 0;
    glitch = 0;
    expect_fetch(8'h00, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    begin
      int n = 0;
      while (!(imem_req && imem_addr == 8'h42) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("reach_42", imem_addr, 8'h42);
    end
    repeat (2) @(negedge clk);
    chk("mid_fetch_req", imem_req, 1);
    chk("ir_held", ir, 16'h1000);
    #2 rst = 0;
    #1;
    chk("async_pc", pc, 0);
    chk("async_req", imem_req, 0);
    chk("async_ir", ir, 0);
    chk("async_halted", halted, 0);
    @(negedge clk);
    ack_delay = 0;
    prog_clear();
    hl[1] = 1;
    expect_fetch(8'h00, 0);
    expect_fetch(8'h01, 3);
    @(negedge clk);
    rst = 1;
    wait_halt();
    chk("reboot_halt_pc", pc, 2);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
